// File: rtl/axil_monitor.sv
// Passive AXI4-Lite monitor: payload stability, outstanding-count and stall-timeout checks on all five channels.
// Define AXIL_MONITOR_ASSERT_EN to add per-flag concurrent assertions and per-channel handshake covers.
module axil_monitor #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [2:0]                    AXI_AWPROT,
    input  logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [2:0]                    AXI_ARPROT,
    input  logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]                    AXI_RRESP,
    input  logic                          AXI_RVALID,
    input  logic                          AXI_RREADY,
    input  logic                          err_clr,
    output logic [8:0]                    err_sticky,
    output logic                          err_pulse,
    output logic [3:0]                    wr_outstanding,
    output logic [3:0]                    rd_outstanding
);

    localparam int NCH = 5;
    localparam int PW  = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH/8 + C_AXI_ADDR_WIDTH + 3;
    localparam int TW  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    MAX_C = 4'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    // Channel index matches the stability-violation bit: 0 AW, 1 W, 2 AR, 3 B, 4 R
    logic [NCH-1:0] vld, rdy, hs;
    logic [PW-1:0]  pay [NCH];

    assign vld = {AXI_RVALID, AXI_BVALID, AXI_ARVALID, AXI_WVALID, AXI_AWVALID};
    assign rdy = {AXI_RREADY, AXI_BREADY, AXI_ARREADY, AXI_WREADY, AXI_AWREADY};
    assign hs  = vld & rdy;

    assign pay[0] = PW'({AXI_AWADDR, AXI_AWPROT});
    assign pay[1] = PW'({AXI_WDATA, AXI_WSTRB});
    assign pay[2] = PW'({AXI_ARADDR, AXI_ARPROT});
    assign pay[3] = PW'(AXI_BRESP);
    assign pay[4] = PW'({AXI_RDATA, AXI_RRESP});

    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] r;
        r = cnt;
        if (inc && !dec && cnt != MAX_C)
            r = cnt + 4'd1;
        else if (dec && !inc && cnt != 4'd0)
            r = cnt - 4'd1;
        return r;
    endfunction

    function automatic logic cnt_ovf(input logic [3:0] cnt, input logic inc, input logic dec);
        return inc && !dec && (cnt == MAX_C);
    endfunction

    // Stage p1: previous-cycle handshake state; chk_en_p1 masks the first cycle after reset
    logic [NCH-1:0] vld_p1, rdy_p1;
    logic [PW-1:0]  pay_p1 [NCH];
    logic           chk_en_p1;
    logic [3:0]     aw_pend_p1, w_pend_p1, rd_pend_p1;
    logic [TW-1:0]  wait_p1 [NCH];

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            vld_p1     <= '0;
            rdy_p1     <= '0;
            chk_en_p1  <= 1'b0;
            aw_pend_p1 <= '0;
            w_pend_p1  <= '0;
            rd_pend_p1 <= '0;
            for (int i = 0; i < NCH; i++) begin
                pay_p1[i]  <= '0;
                wait_p1[i] <= '0;
            end
        end else begin
            vld_p1     <= vld;
            rdy_p1     <= rdy;
            chk_en_p1  <= 1'b1;
            aw_pend_p1 <= cnt_next(aw_pend_p1, hs[0], hs[3]);
            w_pend_p1  <= cnt_next(w_pend_p1,  hs[1], hs[3]);
            rd_pend_p1 <= cnt_next(rd_pend_p1, hs[2], hs[4]);
            for (int i = 0; i < NCH; i++) begin
                pay_p1[i] <= pay[i];
                if (vld[i] && !rdy[i]) begin
                    if (wait_p1[i] != TMAX)
                        wait_p1[i] <= wait_p1[i] + TW'(1);
                end else begin
                    wait_p1[i] <= '0;
                end
            end
        end
    end

    assign wr_outstanding = (aw_pend_p1 < w_pend_p1) ? aw_pend_p1 : w_pend_p1;
    assign rd_outstanding = rd_pend_p1;

    logic [NCH-1:0] stab_err;
    logic           tmo_hit;
    logic           ovf_hit;
    logic [8:0]     err_set;

    always_comb begin
        stab_err = '0;
        tmo_hit  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (vld_p1[i] && !rdy_p1[i] && (!vld[i] || pay[i] != pay_p1[i]))
                stab_err[i] = 1'b1;
            // Fires only on the cycle the wait counter reaches the limit, not while it sits saturated
            if (TIMEOUT_CYCLES > 0 && vld[i] && !rdy[i] && wait_p1[i] == TMAX - TW'(1))
                tmo_hit = 1'b1;
        end
        ovf_hit = cnt_ovf(aw_pend_p1, hs[0], hs[3]) ||
                  cnt_ovf(w_pend_p1,  hs[1], hs[3]) ||
                  cnt_ovf(rd_pend_p1, hs[2], hs[4]);
        err_set = {ovf_hit, tmo_hit,
                   hs[4] && (rd_outstanding == 4'd0),
                   hs[3] && (wr_outstanding == 4'd0),
                   stab_err};
        if (!chk_en_p1)
            err_set = '0;
    end

    // Stage p2: sticky flags and new-set pulse; clear wins over a same-cycle set
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET || err_clr) begin
            err_sticky <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_sticky <= err_sticky | err_set;
            err_pulse  <= |(err_set & ~err_sticky);
        end
    end

`ifdef AXIL_MONITOR_ASSERT_EN
    genvar ga, gc;
    generate
        for (ga = 0; ga < 9; ga++) begin : g_flag_assert
            a_flag: assert property (@(posedge AXI_ACLK) disable iff (AXI_ARESET) !$rose(err_sticky[ga]));
        end
        for (gc = 0; gc < NCH; gc++) begin : g_hs_cover
            c_hs: cover property (@(posedge AXI_ACLK) disable iff (AXI_ARESET) hs[gc]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axil_monitor.sv
// Directed bench for axil_monitor: stability, tracking, overflow, timeout, clear priority and reset.
module tb_axil_monitor;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_ARESET;
    logic [7:0]  AXI_AWADDR;
    logic [2:0]  AXI_AWPROT;
    logic        AXI_AWVALID, AXI_AWREADY;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_WVALID, AXI_WREADY;
    logic [1:0]  AXI_BRESP;
    logic        AXI_BVALID, AXI_BREADY;
    logic [7:0]  AXI_ARADDR;
    logic [2:0]  AXI_ARPROT;
    logic        AXI_ARVALID, AXI_ARREADY;
    logic [31:0] AXI_RDATA;
    logic [1:0]  AXI_RRESP;
    logic        AXI_RVALID, AXI_RREADY;
    logic        err_clr;
    logic [8:0]  err_sticky;
    logic        err_pulse;
    logic [3:0]  wr_outstanding, rd_outstanding;

    int checks = 0;
    int errors = 0;

    axil_monitor #(
        .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8),
        .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .err_clr(err_clr), .err_sticky(err_sticky), .err_pulse(err_pulse),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    task automatic tick();
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        AXI_AWVALID = 0; AXI_AWREADY = 0; AXI_WVALID = 0; AXI_WREADY = 0;
        AXI_BVALID = 0;  AXI_BREADY = 0;  AXI_ARVALID = 0; AXI_ARREADY = 0;
        AXI_RVALID = 0;  AXI_RREADY = 0;  err_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        AXI_ARESET = 1;
        tick();
        AXI_ARESET = 0;
        tick();
        tick();
    endtask

    initial begin
        AXI_ARESET = 1;
        AXI_AWADDR = '0; AXI_AWPROT = '0; AXI_WDATA = '0; AXI_WSTRB = '0; AXI_BRESP = '0;
        AXI_ARADDR = '0; AXI_ARPROT = '0; AXI_RDATA = '0; AXI_RRESP = '0;
        idle();
        tick();
        tick();
        chk("reset_sticky", 32'(err_sticky), 32'h0);
        chk("reset_pulse", 32'(err_pulse), 32'h0);
        chk("reset_wr", 32'(wr_outstanding), 32'h0);
        chk("reset_rd", 32'(rd_outstanding), 32'h0);
        do_reset();

        // AW address changes while stalled
        AXI_AWVALID = 1; AXI_AWADDR = 8'h10;
        tick();
        AXI_AWADDR = 8'h14;
        tick();
        chk("aw_stab_sticky", 32'(err_sticky), 32'h001);
        chk("aw_stab_pulse", 32'(err_pulse), 32'h1);
        tick();
        chk("aw_stab_pulse_once", 32'(err_pulse), 32'h0);
        chk("aw_stab_hold", 32'(err_sticky), 32'h001);

        // Clean write: AW, W, B
        do_reset();
        AXI_AWVALID = 1; AXI_AWREADY = 1; AXI_AWADDR = 8'h20;
        tick();
        chk("wr_after_aw", 32'(wr_outstanding), 32'h0);
        idle(); AXI_WVALID = 1; AXI_WREADY = 1; AXI_WDATA = 32'hCAFE0001; AXI_WSTRB = 4'hF;
        tick();
        chk("wr_after_w", 32'(wr_outstanding), 32'h1);
        idle(); AXI_BVALID = 1; AXI_BREADY = 1; AXI_BRESP = 2'b00;
        tick();
        idle();
        chk("wr_after_b", 32'(wr_outstanding), 32'h0);
        chk("wr_clean_sticky", 32'(err_sticky), 32'h0);

        // B with nothing outstanding
        AXI_BVALID = 1; AXI_BREADY = 1;
        tick();
        idle();
        chk("b_under_sticky", 32'(err_sticky), 32'h020);
        chk("b_under_wr", 32'(wr_outstanding), 32'h0);

        // R with no prior AR
        do_reset();
        AXI_RVALID = 1; AXI_RREADY = 1;
        tick();
        idle();
        chk("r_under_sticky", 32'(err_sticky), 32'h040);
        chk("r_under_pulse", 32'(err_pulse), 32'h1);
        chk("r_under_rd", 32'(rd_outstanding), 32'h0);

        // Five AR handshakes with capacity four
        do_reset();
        AXI_ARVALID = 1; AXI_ARREADY = 1;
        for (int i = 0; i < 4; i++) begin
            AXI_ARADDR = 8'(i * 4);
            tick();
        end
        chk("ar_four_rd", 32'(rd_outstanding), 32'h4);
        chk("ar_four_sticky", 32'(err_sticky), 32'h0);
        AXI_ARADDR = 8'h40;
        tick();
        idle();
        chk("ar_ovf_sticky", 32'(err_sticky), 32'h100);
        chk("ar_ovf_rd", 32'(rd_outstanding), 32'h4);

        // AR stall timeout: set on the 16th stalled cycle, not the 15th
        do_reset();
        AXI_ARVALID = 1; AXI_ARADDR = 8'h33;
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_15", 32'(err_sticky), 32'h0);
        tick();
        chk("tmo_16", 32'(err_sticky), 32'h080);
        chk("tmo_16_pulse", 32'(err_pulse), 32'h1);
        AXI_ARREADY = 1;
        tick();
        idle();
        chk("tmo_then_hs_rd", 32'(rd_outstanding), 32'h1);

        // W strobe change while stalled
        do_reset();
        AXI_WVALID = 1; AXI_WDATA = 32'h12345678; AXI_WSTRB = 4'hF;
        tick();
        AXI_WSTRB = 4'h3;
        tick();
        idle();
        chk("w_stab_sticky", 32'(err_sticky), 32'h002);

        // B valid withdrawn before handshake
        do_reset();
        AXI_BVALID = 1;
        tick();
        AXI_BVALID = 0;
        tick();
        chk("b_stab_sticky", 32'(err_sticky), 32'h008);

        // R data change while stalled
        do_reset();
        AXI_RVALID = 1; AXI_RDATA = 32'hAAAA0000;
        tick();
        AXI_RDATA = 32'hAAAA0001;
        tick();
        idle();
        chk("r_stab_sticky", 32'(err_sticky), 32'h010);

        // err_clr wins over a same-cycle AR stability violation; counter untouched
        do_reset();
        AXI_ARVALID = 1; AXI_ARREADY = 1; AXI_ARADDR = 8'h08;
        tick();
        AXI_ARREADY = 0;
        tick();
        AXI_ARVALID = 0; err_clr = 1;
        tick();
        chk("clr_prio_sticky", 32'(err_sticky), 32'h0);
        chk("clr_prio_pulse", 32'(err_pulse), 32'h0);
        chk("clr_keeps_rd", 32'(rd_outstanding), 32'h1);
        idle();
        tick();
        chk("clr_after_sticky", 32'(err_sticky), 32'h0);

        // Reset in the middle of a write with a flag raised
        do_reset();
        AXI_AWVALID = 1; AXI_AWREADY = 1;
        tick();
        idle(); AXI_WVALID = 1; AXI_WREADY = 1;
        tick();
        idle(); AXI_RVALID = 1; AXI_RREADY = 1;
        tick();
        chk("mid_pre_wr", 32'(wr_outstanding), 32'h1);
        chk("mid_pre_sticky", 32'(err_sticky), 32'h040);
        AXI_ARESET = 1;
        tick();
        chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
        chk("mid_rst_wr", 32'(wr_outstanding), 32'h0);
        chk("mid_rst_pulse", 32'(err_pulse), 32'h0);
        // R handshake held through the first cycle after reset is ignored, then flagged
        AXI_ARESET = 0;
        tick();
        chk("post_rst_masked", 32'(err_sticky), 32'h0);
        tick();
        idle();
        chk("post_rst_checked", 32'(err_sticky), 32'h040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_monitor.md
Name: axil_monitor

Overview:
- Parametrised AXI4-Lite protocol monitor covering all five channels (AW, W, B, AR, R). It supersedes the single-channel AR-ready check.
- Passive tap, placed in parallel with any AXI-Lite master/slave link. Drives no bus signals.
- Tracks handshake stability, outstanding transactions and stall timeouts.
- Reports violations as sticky error flags, usable by RTL, software status registers and benches.

Parameters:
- C_AXI_DATA_WIDTH, 32, data width of WDATA/RDATA; WSTRB width is C_AXI_DATA_WIDTH/8.
- C_AXI_ADDR_WIDTH, 8, address width of AWADDR/ARADDR.
- MAX_OUTSTANDING, 4, max accepted-but-unresponded transactions per direction (1..15).
- TIMEOUT_CYCLES, 16, consecutive VALID-without-READY cycles that flag a stall; 0 disables the timeout check.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESET  in  1  synchronous active-high reset
- AXI_AWADDR/AWPROT/AWVALID/AWREADY  in  ADDR/3/1/1  write address channel
- AXI_WDATA/WSTRB/WVALID/WREADY  in  DATA/DATA/8/1/1  write data channel
- AXI_BRESP/BVALID/BREADY  in  2/1/1  write response channel
- AXI_ARADDR/ARPROT/ARVALID/ARREADY  in  ADDR/3/1/1  read address channel
- AXI_RDATA/RRESP/RVALID/RREADY  in  DATA/2/1/1  read data channel
- err_clr  in  1  clears err_sticky, synchronous
- err_sticky  out  9  sticky violation flags (bit map below)
- err_pulse  out  1  high one cycle when any flag bit newly sets
- wr_outstanding  out  4  pending write responses
- rd_outstanding  out  4  pending read responses

Behaviour:
- Reset: all outputs 0, all counters 0, all previous-cycle registers cleared.
  - No check fires in the reset cycle or in the first cycle after reset.
- Handshake on a channel = VALID & READY at a posedge.
- Stability check: if VALID was high and READY low last cycle, then this cycle VALID must be high and the payload must equal last cycle's payload.
  - Payload per channel: AW = addr+prot; W = data+strb; B = resp; AR = addr+prot; R = data+resp.
  - Violation bits: 0 AW, 1 W, 2 AR, 3 B, 4 R.
- Write tracking:
  - aw_pend increments on AW handshake; w_pend increments on W handshake; both decrement on B handshake.
  - wr_outstanding = min(aw_pend, w_pend).
  - B handshake with registered wr_outstanding == 0 sets bit 5. Counters hold at 0, no underflow.
- Read tracking:
  - rd_outstanding increments on AR handshake, decrements on R handshake.
  - R handshake with registered rd_outstanding == 0 sets bit 6. Counter holds at 0.
- Same-cycle address and response handshakes: net counter change 0. Legality is judged on the registered (pre-cycle) count only.
- Overflow: an increment that would take aw_pend, w_pend or rd_outstanding above MAX_OUTSTANDING sets bit 8. The counter saturates at MAX_OUTSTANDING.
- Timeout:
  - Each of the 5 channels has a wait counter: +1 per cycle with VALID & !READY; cleared on handshake or VALID low.
  - Reaching TIMEOUT_CYCLES sets bit 7. The counter saturates.
- Flag update rules:
  - Flags set at the posedge following the offending sample; err_pulse is asserted in that same cycle.
  - err_clr has priority over a same-cycle set: flags go to 0 and err_pulse is 0 that cycle.
  - err_clr does not affect counters.
- Reset mid-transaction: counters and flags clear. Traffic straddling reset is not checked.

Optional Feature:
- AXIL_MONITOR_ASSERT_EN defined:
  - Adds one concurrent assertion per err_sticky bit, firing on that bit's rising edge, disabled iff AXI_ARESET.
  - Adds a cover property for each channel handshake.
- Undefined: no assertions or covers; flag outputs only. Flag behaviour is identical either way.

Test Plan:
- AWVALID=1, AWADDR=0x10, AWREADY low 3 cycles, AWADDR changes to 0x14 in cycle 2 -> err_sticky[0]=1, err_pulse one cycle, other bits 0.
- AW 0x20 and W handshakes, then B handshake with BRESP=0 -> wr_outstanding 1 then 0, err_sticky=0.
- RVALID&RREADY with no prior AR -> err_sticky[6]=1, rd_outstanding stays 0.
- 5 AR handshakes without R, MAX_OUTSTANDING=4 -> err_sticky[8]=1, rd_outstanding=4.
- ARVALID high, ARREADY low 16 cycles, TIMEOUT_CYCLES=16 -> err_sticky[7] sets on cycle 16, not 15.
- Violation pending with err_clr asserted the same cycle -> err_sticky=0, err_pulse=0. AXI_ARESET mid-write -> all outputs 0 next cycle.
